tx_frame_buffer: RTL and testbench

Ping-pong byte frame buffer that sits directly upstream of the RS485 UART transmitter. It collects acquisition bytes into one bank while the transmitter reads the other bank through its 9-bit address port. It generates the transmitter's start request (RQ) and cycle index (cycle), and consumes the transmitter's completion flag (full). It swaps banks once every cycle index of a frame has been sent.

---
 rtl/tx_frame_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_tx_frame_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_buffer.sv
// -----------------------------------------------------------------------------
// tx_frame_buffer
// Ping-pong byte frame buffer feeding the RS485 UART transmitter. Acquisition
// bytes fill the write bank while the transmitter reads the other bank through
// its address port. One request (RQ) is issued per sendTick; the transmitter
// answers with full. After CYCLES requests the banks swap if a complete new
// frame is waiting. Otherwise the old frame is sent again and underrun is flagged.
//
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   wrEn, wrSof, wrData write strobe, start-of-frame, acquisition byte
//   sendTick            one-cycle strobe requesting the next cycle's bytes
//   addr, data          transmitter read address (bit 8 ignored), registered data
//   cycle, RQ, full     cycle index, request, transmitter completion flag
//   clrFlags            clears the sticky flags below
//   overflow, underrun, timeout, tickMiss   sticky status flags
// -----------------------------------------------------------------------------
module tx_frame_buffer #(
    parameter int          BYTES   = 4,
    parameter int          CYCLES  = 64,
    parameter logic [15:0] TIMEOUT = 16'd4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wrEn,
    input  logic       wrSof,
    input  logic [7:0] wrData,
    input  logic       sendTick,
    input  logic [8:0] addr,
    output logic [7:0] data,
    output logic [5:0] cycle,
    output logic       RQ,
    input  logic       full,
    input  logic       clrFlags,
    output logic       overflow,
    output logic       underrun,
    output logic       timeout,
    output logic       tickMiss
);

    localparam int         FRAME_BYTES = BYTES * CYCLES;
    localparam logic [8:0] FRAME_CNT   = 9'(FRAME_BYTES);
    localparam logic [5:0] LAST_CYCLE  = 6'(CYCLES - 1);

    if (FRAME_BYTES > 256) begin : g_frame_size_check
        $error("tx_frame_buffer: BYTES*CYCLES must not exceed 256");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    logic        done_entry;
    logic [15:0] timer;
    logic        wr_bank;
    logic        rd_bank;
    logic [8:0]  wr_count;
    logic        rd_valid;
    logic [7:0]  mem [0:511];

    logic        frame_full_s;
    logic        frame_end_s;
    logic        first_swap_s;
    logic        swap_s;
    logic        sof_s;
    logic        mem_we_s;
    logic [7:0]  wr_idx_s;
    logic [15:0] timer_inc_s;
    logic        unused_s;

    assign unused_s = addr[8];

    // Write-pointer and bank-swap decode
    always_comb begin
        frame_full_s = (wr_count == FRAME_CNT);
        timer_inc_s  = timer + 16'd1;
        if ((state == ST_DONE) && done_entry && (cycle == LAST_CYCLE)) begin
            frame_end_s = 1'b1;
        end else begin
            frame_end_s = 1'b0;
        end
        // Before any frame is readable a complete bank is published at once
        if ((state == ST_IDLE) && !rd_valid && frame_full_s) begin
            first_swap_s = 1'b1;
        end else begin
            first_swap_s = 1'b0;
        end
        swap_s   = (frame_end_s || first_swap_s) && frame_full_s;
        // A complete bank ignores wrSof so the frame is not lost before the swap
        sof_s    = wrSof && !frame_full_s;
        mem_we_s = wrEn && !frame_full_s;
        if (sof_s) begin
            wr_idx_s = 8'd0;
        end else begin
            wr_idx_s = wr_count[7:0];
        end
    end

    // Byte storage write port (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[{wr_bank, wr_idx_s}] <= wrData;
        end
    end

    // Registered read port; output held at zero until a frame is valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            data <= 8'd0;
        end else if (rd_valid) begin
            data <= mem[{rd_bank, addr[7:0]}];
        end else begin
            data <= 8'd0;
        end
    end

    // Write side, bank control, request FSM and sticky flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            done_entry <= 1'b0;
            timer      <= 16'd0;
            RQ         <= 1'b0;
            cycle      <= 6'd0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b1;
            wr_count   <= 9'd0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
            timeout    <= 1'b0;
            tickMiss   <= 1'b0;
        end else begin
            // Clear first so that any set event below in the same cycle wins
            if (clrFlags) begin
                overflow <= 1'b0;
                underrun <= 1'b0;
                timeout  <= 1'b0;
                tickMiss <= 1'b0;
            end

            if (swap_s) begin
                wr_bank  <= ~wr_bank;
                rd_bank  <= ~rd_bank;
                wr_count <= 9'd0;
                rd_valid <= 1'b1;
            end else if (mem_we_s) begin
                wr_count <= {1'b0, wr_idx_s} + 9'd1;
            end else if (sof_s) begin
                wr_count <= 9'd0;
            end

            if (wrEn && frame_full_s) begin
                overflow <= 1'b1;
            end
            if (frame_end_s && !frame_full_s && rd_valid) begin
                underrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    done_entry <= 1'b0;
                    if (sendTick && rd_valid) begin
                        state <= ST_REQ;
                        RQ    <= 1'b1;
                        timer <= 16'd0;
                    end
                end
                ST_REQ: begin
                    timer <= timer_inc_s;
                    if (sendTick) begin
                        tickMiss <= 1'b1;
                    end
                    if (full) begin
                        RQ         <= 1'b0;
                        state      <= ST_DONE;
                        done_entry <= 1'b1;
                    end else if (timer_inc_s == TIMEOUT) begin
                        // RQ has then been high for exactly TIMEOUT clocks
                        RQ         <= 1'b0;
                        timeout    <= 1'b1;
                        state      <= ST_DONE;
                        done_entry <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (sendTick) begin
                        tickMiss <= 1'b1;
                    end
                    if (done_entry) begin
                        done_entry <= 1'b0;
                        if (cycle == LAST_CYCLE) begin
                            cycle <= 6'd0;
                        end else begin
                            cycle <= cycle + 6'd1;
                        end
                    end else if (!full) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    RQ         <= 1'b0;
                    done_entry <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_buffer.sv
module tb_tx_frame_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       wrEn;
    logic       wrSof;
    logic [7:0] wrData;
    logic       sendTick;
    logic [8:0] addr;
    logic [7:0] data;
    logic [5:0] cycle;
    logic       RQ;
    logic       full;
    logic       clrFlags;
    logic       overflow;
    logic       underrun;
    logic       timeout;
    logic       tickMiss;

    int total = 0;
    int bad   = 0;

    tx_frame_buffer dut (
        .clk(clk), .reset(reset), .wrEn(wrEn), .wrSof(wrSof), .wrData(wrData),
        .sendTick(sendTick), .addr(addr), .data(data), .cycle(cycle), .RQ(RQ),
        .full(full), .clrFlags(clrFlags), .overflow(overflow), .underrun(underrun),
        .timeout(timeout), .tickMiss(tickMiss)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte pattern per frame kind
    function automatic logic [7:0] pat(input int mode, input int i);
        logic [7:0] b;
        b = 8'(i);
        case (mode)
            0:       return b;
            1:       return 8'd255 - b;
            2:       return b ^ 8'h5A;
            default: return 8'hC3;
        endcase
    endfunction

    task automatic write_bytes(input int first, input int n, input int mode, input bit sof);
        for (int i = first; i < first + n; i++) begin
            wrEn   = 1'b1;
            wrSof  = sof && (i == first);
            wrData = pat(mode, i);
            tick();
        end
        wrEn  = 1'b0;
        wrSof = 1'b0;
    endtask

    task automatic read_byte(input logic [8:0] a, output logic [7:0] d);
        addr = a;
        tick();
        d = data;
    endtask

    // One request/acknowledge handshake with full rising after delay+1 clocks
    task automatic do_request(input int delay, output logic rq_up, output logic rq_hold,
                              output logic rq_down, output logic [5:0] cyc);
        sendTick = 1'b1;
        tick();
        sendTick = 1'b0;
        rq_up   = RQ;
        rq_hold = 1'b1;
        repeat (delay) begin
            tick();
            rq_hold = rq_hold & RQ;
        end
        full = 1'b1;
        tick();
        rq_down = RQ;
        tick();
        cyc  = cycle;
        full = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; wrEn = 1'b0; wrSof = 1'b0; wrData = 8'd0; sendTick = 1'b0;
        addr = 9'd0; full = 1'b0; clrFlags = 1'b0;
        tick(); tick();
        total++; if (RQ !== 1'b0) begin bad++; $display("FAIL reset_rq got=%b want=0", RQ); end
        total++; if (cycle !== 6'd0) begin bad++; $display("FAIL reset_cycle got=%0d want=0", cycle); end
        total++; if (data !== 8'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", data); end
        total++; if ({overflow, underrun, timeout, tickMiss} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {overflow, underrun, timeout, tickMiss});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_first_frame();
        logic [7:0] d;
        logic up, hold, down;
        logic [5:0] cyc;
        write_bytes(0, 255, 0, 1'b1);
        sendTick = 1'b1; tick(); sendTick = 1'b0;
        total++; if (RQ !== 1'b0) begin bad++; $display("FAIL no_frame_tick_rq got=%b want=0", RQ); end
        total++; if (tickMiss !== 1'b0) begin bad++; $display("FAIL no_frame_tickmiss got=%b want=0", tickMiss); end
        read_byte(9'd5, d);
        total++; if (d !== 8'd0) begin bad++; $display("FAIL invalid_read got=%0d want=0", d); end
        write_bytes(255, 1, 0, 1'b0);
        tick();
        read_byte(9'd0, d);
        total++; if (d !== 8'd0) begin bad++; $display("FAIL read_a0 got=%0d want=0", d); end
        addr = 9'd3;
        #1;
        total++; if (data !== 8'd0) begin bad++; $display("FAIL read_latency got=%0d want=0", data); end
        tick();
        total++; if (data !== 8'd3) begin bad++; $display("FAIL read_a3 got=%0d want=3", data); end
        read_byte(9'd1, d);
        total++; if (d !== 8'd1) begin bad++; $display("FAIL read_a1 got=%0d want=1", d); end
        read_byte(9'd2, d);
        total++; if (d !== 8'd2) begin bad++; $display("FAIL read_a2 got=%0d want=2", d); end
        read_byte(9'h1FF, d);
        total++; if (d !== 8'd255) begin bad++; $display("FAIL read_a8_ignored got=%0d want=255", d); end
        do_request(59, up, hold, down, cyc);
        total++; if (up !== 1'b1) begin bad++; $display("FAIL first_rq_up got=%b want=1", up); end
        total++; if (hold !== 1'b1) begin bad++; $display("FAIL first_rq_hold got=%b want=1", hold); end
        total++; if (down !== 1'b0) begin bad++; $display("FAIL first_rq_down got=%b want=0", down); end
        total++; if (cyc !== 6'd1) begin bad++; $display("FAIL first_cycle got=%0d want=1", cyc); end
    endtask

    task automatic test_frame_swap();
        logic [7:0] d;
        logic up, hold, down;
        logic [5:0] cyc;
        write_bytes(0, 256, 1, 1'b1);
        for (int j = 0; j < 63; j++) begin
            if (j == 62) begin
                read_byte(9'd0, d);
                total++; if (d !== 8'd0) begin bad++; $display("FAIL pre_swap_a0 got=%0d want=0", d); end
            end
            do_request(1, up, hold, down, cyc);
            total++; if (cyc !== 6'((j + 2) % 64)) begin
                bad++; $display("FAIL swap_cycle_%0d got=%0d want=%0d", j, cyc, (j + 2) % 64);
            end
        end
        read_byte(9'd0, d);
        total++; if (d !== 8'd255) begin bad++; $display("FAIL swap_a0 got=%0d want=255", d); end
        read_byte(9'd5, d);
        total++; if (d !== 8'd250) begin bad++; $display("FAIL swap_a5 got=%0d want=250", d); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL swap_underrun got=%b want=0", underrun); end
    endtask

    task automatic test_underrun();
        logic [7:0] d;
        logic up, hold, down;
        logic [5:0] cyc;
        write_bytes(0, 100, 2, 1'b1);
        for (int j = 0; j < 64; j++) begin
            if (j == 63) begin
                total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_early got=%b want=0", underrun); end
            end
            do_request(1, up, hold, down, cyc);
        end
        total++; if (cycle !== 6'd0) begin bad++; $display("FAIL underrun_cycle got=%0d want=0", cycle); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set got=%b want=1", underrun); end
        read_byte(9'd0, d);
        total++; if (d !== 8'd255) begin bad++; $display("FAIL resend_a0 got=%0d want=255", d); end
        // Finish the partial frame without restarting the pointer
        write_bytes(100, 156, 2, 1'b0);
        for (int j = 0; j < 64; j++) begin
            do_request(1, up, hold, down, cyc);
        end
        read_byte(9'd0, d);
        total++; if (d !== pat(2, 0)) begin bad++; $display("FAIL cont_a0 got=%0d want=%0d", d, pat(2, 0)); end
        read_byte(9'd100, d);
        total++; if (d !== pat(2, 100)) begin bad++; $display("FAIL cont_a100 got=%0d want=%0d", d, pat(2, 100)); end
        read_byte(9'd255, d);
        total++; if (d !== pat(2, 255)) begin bad++; $display("FAIL cont_a255 got=%0d want=%0d", d, pat(2, 255)); end
    endtask

    task automatic test_overflow();
        write_bytes(0, 256, 3, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b want=0", overflow); end
        wrEn = 1'b1; wrData = 8'h77; tick(); wrEn = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_257th got=%b want=1", overflow); end
        clrFlags = 1'b1; tick(); clrFlags = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear got=%b want=0", underrun); end
        wrSof = 1'b1; tick(); wrSof = 1'b0;
        wrEn = 1'b1; tick(); wrEn = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sof_ignored got=%b want=1", overflow); end
        clrFlags = 1'b1; tick();
        wrEn = 1'b1; tick(); wrEn = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL set_beats_clear got=%b want=1", overflow); end
        tick(); clrFlags = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear2 got=%b want=0", overflow); end
    endtask

    task automatic test_timeout();
        int n;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_before got=%b want=0", timeout); end
        sendTick = 1'b1; tick(); sendTick = 1'b0;
        total++; if (RQ !== 1'b1) begin bad++; $display("FAIL timeout_rq_up got=%b want=1", RQ); end
        n = 0;
        while (RQ === 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        total++; if (n !== 4095) begin bad++; $display("FAIL timeout_len got=%0d want=4095", n); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b want=1", timeout); end
        tick();
        total++; if (cycle !== 6'd1) begin bad++; $display("FAIL timeout_cycle got=%0d want=1", cycle); end
        tick();
    endtask

    task automatic test_tick_miss();
        clrFlags = 1'b1; tick(); clrFlags = 1'b0;
        total++; if (tickMiss !== 1'b0) begin bad++; $display("FAIL tickmiss_before got=%b want=0", tickMiss); end
        sendTick = 1'b1; tick(); sendTick = 1'b0;
        tick();
        sendTick = 1'b1; tick(); sendTick = 1'b0;
        total++; if (tickMiss !== 1'b1) begin bad++; $display("FAIL tickmiss_set got=%b want=1", tickMiss); end
        total++; if (RQ !== 1'b1) begin bad++; $display("FAIL tickmiss_rq got=%b want=1", RQ); end
        full = 1'b1; tick();
        total++; if (RQ !== 1'b0) begin bad++; $display("FAIL tickmiss_rq_down got=%b want=0", RQ); end
        tick();
        total++; if (cycle !== 6'd2) begin bad++; $display("FAIL tickmiss_cycle got=%0d want=2", cycle); end
        full = 1'b0;
        tick(); tick(); tick(); tick();
        total++; if (RQ !== 1'b0) begin bad++; $display("FAIL no_second_rq got=%b want=0", RQ); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        sendTick = 1'b1; tick(); sendTick = 1'b0;
        total++; if (RQ !== 1'b1) begin bad++; $display("FAIL mid_rq_up got=%b want=1", RQ); end
        reset = 1'b0; tick();
        total++; if (RQ !== 1'b0) begin bad++; $display("FAIL mid_rq_reset got=%b want=0", RQ); end
        total++; if (cycle !== 6'd0) begin bad++; $display("FAIL mid_cycle_reset got=%0d want=0", cycle); end
        total++; if (tickMiss !== 1'b0) begin bad++; $display("FAIL mid_flags_reset got=%b want=0", tickMiss); end
        reset = 1'b1; tick();
        read_byte(9'd0, d);
        total++; if (d !== 8'd0) begin bad++; $display("FAIL post_reset_data got=%0d want=0", d); end
        sendTick = 1'b1; tick(); sendTick = 1'b0;
        total++; if (RQ !== 1'b0) begin bad++; $display("FAIL post_reset_tick got=%b want=0", RQ); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_frame_swap();
        test_underrun();
        test_overflow();
        test_timeout();
        test_tick_miss();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
